// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB state encoding and default bus widths
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_state_t;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

endpackage

// File: rtl/apb_timeout_cnt.sv
// rtl/apb_timeout_cnt.sv - ACCESS-phase wait counter; flags the cycle that reaches LIMIT
module apb_timeout_cnt #(
    parameter int LIMIT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Fires on the LIMIT-th stalled cycle so the abort lands after exactly LIMIT waits.
    assign expired_o = enable_i & (count_q == CW'(LIMIT - 1));

endmodule

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - single-outstanding valid/ready to APB requester
// Optional ACCESS timeout abort enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W         = APB_ADDR_W,
    parameter int DATA_W         = APB_DATA_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic              PREADY,
    input  logic [DATA_W-1:0] PRDATA
);

    apb_state_t        state_q, state_d;
    logic              pwrite_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic              resp_valid_q;
    logic [DATA_W-1:0] resp_rdata_q;
    logic              accept;
    logic              done;
    logic              expired;

    assign req_ready = (state_q == IDLE) & ~PRESET;
    assign accept    = req_valid & req_ready;
    assign done      = (state_q == ACCESS) & PREADY;

`ifdef APB_MASTER_TIMEOUT_EN
    logic resp_err_q;

    apb_timeout_cnt #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk_i    (PCLK),
        .rst_i    (PRESET),
        .clear_i  (state_q == SETUP),
        .enable_i ((state_q == ACCESS) & ~PREADY),
        .expired_o(expired)
    );

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            resp_err_q <= 1'b0;
        end else begin
            resp_err_q <= expired;
        end
    end

    assign resp_err = resp_err_q;
`else
    logic unused_cfg;

    assign unused_cfg = (TIMEOUT_CYCLES > 0);
    assign expired    = 1'b0;
    assign resp_err   = 1'b0;
`endif

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (done || expired) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        PSEL    = (state_q == SETUP) || (state_q == ACCESS);
        PENABLE = (state_q == ACCESS);
    end

    // Command fields are only captured on accept, so they hold through SETUP/ACCESS and linger in IDLE.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            if (accept) begin
                pwrite_q <= req_write;
                paddr_q  <= req_addr;
                pwdata_q <= req_wdata;
            end
            resp_valid_q <= done | expired;
            if (done || expired) begin
                resp_rdata_q <= (done && !pwrite_q) ? PRDATA : '0;
            end
        end
    end

    assign PWRITE     = pwrite_q;
    assign PADDR      = paddr_q;
    assign PWDATA     = pwdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - randomized transaction-level check of apb_master_bridge
module tb_apb_master_bridge;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic        PREADY;
    logic [31:0] PRDATA;

    int n_vec  = 0;
    int n_miss = 0;

    logic [31:0] ref_mem   [logic [31:0]];
    logic [31:0] slave_mem [logic [31:0]];

    always #5 PCLK = ~PCLK;

    apb_master_bridge dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PREADY    (PREADY),
        .PRDATA    (PRDATA)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    function automatic logic [31:0] slave_read(input logic [31:0] a);
        return slave_mem.exists(a) ? slave_mem[a] : init_val(a);
    endfunction

    // Called at a negedge with the bridge idle; returns at the negedge of the response cycle.
    task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input int waits, input bit hold);
        logic [31:0] exp_rd;
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        @(negedge PCLK);
        req_valid = hold;
        req_write = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        chk("setup_psel", PSEL, 1);
        chk("setup_penable", PENABLE, 0);
        chk("setup_pwrite", PWRITE, wr);
        chk("setup_paddr", PADDR, a);
        if (wr) chk("setup_pwdata", PWDATA, d);
        chk("setup_req_ready", req_ready, 0);
        chk("setup_resp_valid", resp_valid, 0);
        @(negedge PCLK);
        for (int i = 0; i <= waits; i++) begin
            chk("access_psel", PSEL, 1);
            chk("access_penable", PENABLE, 1);
            chk("access_paddr", PADDR, a);
            chk("access_pwrite", PWRITE, wr);
            if (wr) chk("access_pwdata", PWDATA, d);
            chk("access_resp_valid", resp_valid, 0);
            chk("access_req_ready", req_ready, 0);
            PREADY = (i == waits);
            PRDATA = (i == waits) ? slave_read(PADDR) : $urandom;
            if (i == waits && PWRITE && PSEL && PENABLE) slave_mem[PADDR] = PWDATA;
            @(negedge PCLK);
            PREADY = 1'b0;
            PRDATA = $urandom;
        end
        exp_rd = wr ? 32'h0 : ref_read(a);
        if (wr) ref_mem[a] = d;
        chk("resp_valid", resp_valid, 1);
        chk("resp_rdata", resp_rdata, exp_rd);
        chk("resp_err", resp_err, 0);
        chk("resp_psel", PSEL, 0);
        chk("resp_penable", PENABLE, 0);
        chk("resp_req_ready", req_ready, 1);
        req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        PRESET    = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        PREADY    = 1'b0;
        PRDATA    = '0;
        repeat (3) @(negedge PCLK);
        chk("rst_psel", PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_pwrite", PWRITE, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_pwdata", PWDATA, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_req_ready", req_ready, 0);
        PRESET = 1'b0;
        @(negedge PCLK);

        xfer(1'b1, 32'h4, 32'hDEADBEEF, 0, 1'b0);
        @(negedge PCLK);
        chk("resp_pulse_width", resp_valid, 0);
        xfer(1'b0, 32'h4, 32'h0, 0, 1'b0);
        xfer(1'b0, 32'h4, 32'h0, 3, 1'b0);

        for (int k = 0; k < 4; k++) begin
            xfer(1'b1, 32'(k), $urandom, 0, 1'b1);
        end
        @(negedge PCLK);
        chk("b2b_idle_resp", resp_valid, 0);
        chk("b2b_idle_psel", PSEL, 0);

        for (int k = 0; k < 40; k++) begin
            xfer(1'($urandom), 32'($urandom_range(0, 7)) << 2, $urandom,
                 int'($urandom_range(0, 3)), 1'($urandom));
            if ($urandom_range(0, 1) == 1) @(negedge PCLK);
        end

        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h10;
        req_wdata = 32'hCAFE_F00D;
        @(negedge PCLK);
        req_valid = 1'b0;
        @(negedge PCLK);
        chk("prst_in_access", PENABLE, 1);
        PRESET = 1'b1;
        @(negedge PCLK);
        chk("prst_psel", PSEL, 0);
        chk("prst_penable", PENABLE, 0);
        chk("prst_resp_valid", resp_valid, 0);
        chk("prst_req_ready", req_ready, 0);
        PRESET = 1'b0;
        @(negedge PCLK);
        chk("prst_release_ready", req_ready, 1);
        chk("prst_release_resp", resp_valid, 0);
        xfer(1'b0, 32'h10, 32'h0, 1, 1'b0);

`ifdef APB_MASTER_TIMEOUT_EN
        xfer(1'b0, 32'h4, 32'h0, 15, 1'b0);
        begin
            int n_acc;
            req_valid = 1'b1;
            req_write = 1'b0;
            req_addr  = 32'h8;
            @(negedge PCLK);
            req_valid = 1'b0;
            @(negedge PCLK);
            n_acc = 0;
            while (PSEL && PENABLE && n_acc < 40) begin
                PREADY = 1'b0;
                PRDATA = $urandom;
                n_acc++;
                @(negedge PCLK);
            end
            chk("tmo_access_cycles", 64'(n_acc), 64'd16);
            chk("tmo_resp_valid", resp_valid, 1);
            chk("tmo_resp_err", resp_err, 1);
            chk("tmo_resp_rdata", resp_rdata, 0);
            chk("tmo_req_ready", req_ready, 1);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
